alu_seq_ctrl: RTL

//   Multi-cycle sequencer around a single shared four_bit_adder_subtractor instance.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_ctrl_addsub.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: operation codes, FSM states and
// the iteration count of the multi-cycle MUL/DIV loops.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int ITER_MULDIV = 4;

endpackage

// File: rtl/alu_seq_ctrl_addsub.sv
// 4-bit ripple-carry adder/subtractor shared by every ALU operation.
// With sub=1 it computes a + ~b + 1, so cout=1 means a >= b (no borrow).
module four_bit_adder_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;
    logic [3:0] b_eff;

    assign carry[0] = sub;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign b_eff[gi]   = b[gi] ^ sub;
            assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: ADD/SUB in one adder pass, MUL/DIV as 4-pass
// shift-add / restoring-divide loops, all through one shared adder.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter logic [3:0] DIV_ZERO_Q = 4'hF,
    parameter bit         ENABLE_DIV = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       flag,
    output logic       err
);

    localparam logic [1:0] LAST_ITER = 2'(ITER_MULDIV - 1);

    state_e     state_reg;
    op_e        op_reg;
    logic [3:0] a_reg, b_reg;
    logic [3:0] acc_reg, mq_reg;   // MUL: acc/multiplier; DIV: remainder/quotient
    logic [1:0] cnt_reg;
    logic       bad_div_reg;
    logic [7:0] result_reg;
    logic       flag_reg, err_reg, out_valid_reg, in_ready_reg;

    logic [3:0] add_a, add_b, add_sum;
    logic       add_sub, add_cout;
    logic [4:0] div_sh;
    logic       div_take;
    logic [3:0] mul_acc_next, mul_mq_next, div_rem_next, div_q_next;
    logic       run_done;
    logic [7:0] result_next;
    logic       flag_next, err_next;

    assign div_sh = {acc_reg, mq_reg[3]};

    always_comb begin
        add_a   = a_reg;
        add_b   = b_reg;
        add_sub = 1'b0;
        case (op_reg)
            OP_SUB: add_sub = 1'b1;
            OP_MUL: begin
                add_a = acc_reg;
                add_b = mq_reg[0] ? a_reg : 4'h0;
            end
            OP_DIV: begin
                add_a   = div_sh[3:0];
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    four_bit_adder_subtractor u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A set shifted-out bit means the partial remainder already exceeds the divisor.
    assign div_take     = add_cout | div_sh[4];
    assign div_rem_next = div_take ? add_sum : div_sh[3:0];
    assign div_q_next   = {mq_reg[2:0], div_take};
    assign mul_acc_next = {add_cout, add_sum[3:1]};
    assign mul_mq_next  = {add_sum[0], mq_reg[3:1]};

    always_comb begin
        run_done    = 1'b0;
        result_next = result_reg;
        flag_next   = 1'b0;
        err_next    = 1'b0;
        if (bad_div_reg) begin
            run_done    = 1'b1;
            result_next = ENABLE_DIV ? {a_reg, DIV_ZERO_Q} : 8'h00;
            err_next    = 1'b1;
        end else begin
            case (op_reg)
                OP_ADD: begin
                    run_done    = 1'b1;
                    result_next = {3'b000, add_cout, add_sum};
                    flag_next   = add_cout;
                end
                OP_SUB: begin
                    run_done    = 1'b1;
                    result_next = {4'h0, add_sum};
                    flag_next   = ~add_cout;
                end
                OP_MUL: begin
                    run_done    = (cnt_reg == LAST_ITER);
                    result_next = {mul_acc_next, mul_mq_next};
                end
                default: begin
                    run_done    = (cnt_reg == LAST_ITER);
                    result_next = {div_rem_next, div_q_next};
                end
            endcase
        end
    end

    // Rejected divides still spend one RUN cycle so their latency matches ADD/SUB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_ADD;
            a_reg         <= 4'h0;
            b_reg         <= 4'h0;
            acc_reg       <= 4'h0;
            mq_reg        <= 4'h0;
            cnt_reg       <= 2'd0;
            bad_div_reg   <= 1'b0;
            result_reg    <= 8'h00;
            flag_reg      <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg       <= op_e'(op);
                        a_reg        <= a;
                        b_reg        <= b;
                        acc_reg      <= 4'h0;
                        mq_reg       <= (op_e'(op) == OP_MUL) ? b : a;
                        cnt_reg      <= 2'd0;
                        bad_div_reg  <= (op_e'(op) == OP_DIV) && ((b == 4'h0) || !ENABLE_DIV);
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_reg <= cnt_reg + 2'd1;
                    if (op_reg == OP_MUL) begin
                        acc_reg <= mul_acc_next;
                        mq_reg  <= mul_mq_next;
                    end else if (op_reg == OP_DIV) begin
                        acc_reg <= div_rem_next;
                        mq_reg  <= div_q_next;
                    end
                    if (run_done) begin
                        result_reg    <= result_next;
                        flag_reg      <= flag_next;
                        err_reg       <= err_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flag      = flag_reg;
    assign err       = err_reg;

endmodule
